// File: rtl/pong_pkg.sv
// Shared playfield geometry and paddle direction encoding for the pong
// datapath (paddle driver and ball block).
package pong_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PADDLE_H = 120;
    localparam int COORD_W  = 10;
    localparam int Y_MAX    = SCREEN_H - PADDLE_H;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } paddle_dir_e;

endpackage

// File: rtl/paddle_driver_button_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw
// push button. level only changes after the synchronised input has
// disagreed with it for DEBOUNCE consecutive ticks.
module button_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic slowclock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE - 1);

    logic       sync_1;
    logic       sync_2;
    logic [3:0] stable_cnt;

    // bring the asynchronous button into the slowclock domain
    always_ff @(posedge slowclock or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // count ticks of disagreement; flip the level once the count completes
    always_ff @(posedge slowclock or negedge reset) begin
        if (!reset) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (sync_2 == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            stable_cnt <= '0;
            level      <= ~level;
        end else begin
            stable_cnt <= stable_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/paddle_driver.sv
// Left paddle position generator. Debounced up/down buttons drive a
// direction FSM with hold-to-accelerate stepping; position is clamped to
// 0..Y_MAX. Optional ball-tracking mode is built when AUTO_PADDLE_EN is
// defined (adds ball_y and auto_mode inputs).
module paddle_driver
    import pong_pkg::*;
#(
    parameter int Y_INIT      = 180,
    parameter int DEBOUNCE    = 4,
    parameter int STEP        = 2,
    parameter int STEP_FAST   = 6,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                  slowclock,
    input  logic                  reset,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  recenter,
`ifdef AUTO_PADDLE_EN
    input  logic [COORD_W-1:0]    ball_y,
    input  logic                  auto_mode,
`endif
    output logic [COORD_W-1:0]    paddle_y,
    output logic                  at_top,
    output logic                  at_bottom,
    output logic [1:0]            dir
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [COORD_W-1:0] Y_INIT_C = COORD_W'(Y_INIT);
    localparam logic [COORD_W-1:0] Y_MAX_C  = COORD_W'(Y_MAX);
    localparam logic [COORD_W:0]   Y_MAX_W  = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W:0]   STEP_C   = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0]   FAST_C   = (COORD_W+1)'(STEP_FAST);
    localparam logic [HOLD_W-1:0]  HOLD_C   = HOLD_W'(HOLD_CYCLES);

    logic                  db_up;
    logic                  db_down;
    paddle_dir_e           state;
    paddle_dir_e           next_state;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [HOLD_W-1:0]     hold_next;
    logic [COORD_W:0]      step_w;
    logic [COORD_W:0]      paddle_w;
    logic [COORD_W:0]      sum_w;
    logic [COORD_W:0]      diff_w;
    logic [COORD_W-1:0]    y_next;

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_up (
        .slowclock (slowclock),
        .reset     (reset),
        .raw       (btn_up),
        .level     (db_up)
    );

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_down (
        .slowclock (slowclock),
        .reset     (reset),
        .raw       (btn_down),
        .level     (db_down)
    );

    assign paddle_w = {1'b0, paddle_y};
    assign sum_w    = paddle_w + step_w;
    // bit COORD_W of the difference is the borrow: set when paddle_y < step
    assign diff_w   = paddle_w - step_w;
    assign dir      = state;

`ifdef AUTO_PADDLE_EN
    logic signed [COORD_W+1:0] ball_off;
    logic [COORD_W-1:0]        target;
    logic [COORD_W:0]          target_w;

    // tracking target: paddle centred on the ball, clamped to the field
    always_comb begin
        ball_off = $signed({2'b00, ball_y}) - $signed((COORD_W+2)'(PADDLE_H / 2));
        target   = '0;
        if (ball_off < 0) begin
            target = '0;
        end else if (ball_off > $signed((COORD_W+2)'(Y_MAX))) begin
            target = Y_MAX_C;
        end else begin
            target = ball_off[COORD_W-1:0];
        end
        target_w = {1'b0, target};
    end
`endif

    // direction decision from debounced buttons (or the tracker)
    always_comb begin
        next_state = IDLE;
        if (db_up && !db_down) begin
            next_state = UP;
        end else if (db_down && !db_up) begin
            next_state = DOWN;
        end
`ifdef AUTO_PADDLE_EN
        if (auto_mode) begin
            next_state = IDLE;
            if (paddle_w > target_w + STEP_C) begin
                next_state = UP;
            end else if (paddle_w + STEP_C < target_w) begin
                next_state = DOWN;
            end
        end
`endif
    end

    // step size and hold counter; idle or reversal restarts acceleration
    always_comb begin
        step_w    = (hold_cnt < HOLD_C) ? STEP_C : FAST_C;
        hold_next = hold_cnt;
        if (next_state == IDLE || (state != IDLE && next_state != state)) begin
            hold_next = '0;
        end else if (state != IDLE && hold_cnt < HOLD_C) begin
            hold_next = hold_cnt + 1'b1;
        end
`ifdef AUTO_PADDLE_EN
        if (auto_mode) begin
            step_w    = STEP_C;
            hold_next = '0;
        end
`endif
    end

    // clamped position update driven by the registered direction
    always_comb begin
        y_next = paddle_y;
        case (state)
            UP:      y_next = diff_w[COORD_W] ? '0 : diff_w[COORD_W-1:0];
            DOWN:    y_next = (sum_w > Y_MAX_W) ? Y_MAX_C : sum_w[COORD_W-1:0];
            default: y_next = paddle_y;
        endcase
    end

    // direction FSM, hold counter, position and limit flags
    always_ff @(posedge slowclock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            paddle_y  <= Y_INIT_C;
            at_top    <= 1'b0;
            at_bottom <= 1'b0;
        end else if (recenter) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            paddle_y  <= Y_INIT_C;
            at_top    <= (Y_INIT_C == '0);
            at_bottom <= (Y_INIT_C == Y_MAX_C);
        end else begin
            state     <= next_state;
            hold_cnt  <= hold_next;
            paddle_y  <= y_next;
            at_top    <= (y_next == '0);
            at_bottom <= (y_next == Y_MAX_C);
        end
    end

endmodule

// File: tb/tb_paddle_driver.sv
// Directed bench for paddle_driver. Edge numbers below count slowclock
// rising edges after the one labelled 0 in restart(); buttons change just
// after edge 0, and outputs are sampled 1 ns after each edge.
module tb_paddle_driver;

    logic       slowclock = 1'b0;
    logic       reset     = 1'b0;
    logic       btn_up    = 1'b0;
    logic       btn_down  = 1'b0;
    logic       recenter  = 1'b0;
    logic [9:0] paddle_y;
    logic       at_top;
    logic       at_bottom;
    logic [1:0] dir;
`ifdef AUTO_PADDLE_EN
    logic [9:0] ball_y    = 10'd0;
    logic       auto_mode = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    paddle_driver dut (
        .slowclock (slowclock),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .recenter  (recenter),
`ifdef AUTO_PADDLE_EN
        .ball_y    (ball_y),
        .auto_mode (auto_mode),
`endif
        .paddle_y  (paddle_y),
        .at_top    (at_top),
        .at_bottom (at_bottom),
        .dir       (dir)
    );

    always #5 slowclock = ~slowclock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    endtask

    task automatic tick();
        @(posedge slowclock);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic restart();
        reset    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        recenter = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        edge_n = 0;
    endtask

    initial begin
        // reset values while held, and after release
        repeat (3) tick();
        check("rst_y", paddle_y, 180);
        check("rst_dir", dir, 0);
        check("rst_top", at_top, 0);
        check("rst_bot", at_bottom, 0);
        reset = 1'b1;
        tick();
        check("rel_y", paddle_y, 180);
        check("rel_dir", dir, 0);

        // up held: latency, slow steps, then acceleration
        restart();
        btn_up = 1'b1;
        run_to(6);  check("up_dir6", dir, 0);
        run_to(7);  check("up_y7", paddle_y, 180); check("up_dir7", dir, 1);
        run_to(8);  check("up_y8", paddle_y, 178);
        run_to(23); check("up_y23", paddle_y, 148);
        run_to(24); check("up_y24_fast", paddle_y, 142);
        // asynchronous reset mid-movement, checked before the next edge
        #2 reset = 1'b0;
        #1;
        check("async_rst_y", paddle_y, 180);
        check("async_rst_dir", dir, 0);
        btn_up = 1'b0;

        // down held to the bottom limit, with a clamped fast step
        restart();
        btn_down = 1'b1;
        run_to(8);  check("dn_y8", paddle_y, 182);
        run_to(23); check("dn_y23", paddle_y, 212);
        run_to(24); check("dn_y24", paddle_y, 218);
        run_to(46); check("dn_y46", paddle_y, 350); check("dn_bot46", at_bottom, 0);
        run_to(47); check("dn_y47", paddle_y, 356);
        run_to(48); check("dn_y48_clamp", paddle_y, 360); check("dn_bot48", at_bottom, 1);
        run_to(50); check("dn_y50_stick", paddle_y, 360); check("dn_bot50", at_bottom, 1);
        check("dn_dir50", dir, 2);

        // reverse at the bottom: slow restart, then fast up into the top limit
        btn_down = 1'b0;
        btn_up   = 1'b1;
        run_to(56);  check("rev_dir56", dir, 2);
        run_to(57);  check("rev_dir57", dir, 1); check("rev_y57", paddle_y, 360);
        run_to(58);  check("rev_y58", paddle_y, 358); check("rev_bot58", at_bottom, 0);
        run_to(59);  check("rev_y59", paddle_y, 356);
        run_to(73);  check("rev_y73", paddle_y, 328);
        run_to(74);  check("rev_y74_fast", paddle_y, 322);
        run_to(127); check("top_y127", paddle_y, 4); check("top_flag127", at_top, 0);
        run_to(128); check("top_y128_clamp", paddle_y, 0); check("top_flag128", at_top, 1);
        run_to(130); check("top_y130_stick", paddle_y, 0); check("top_flag130", at_top, 1);

        // recenter while moving down fast
        restart();
        btn_down = 1'b1;
        run_to(30); check("rc_y30", paddle_y, 254);
        recenter = 1'b1;
        run_to(31);
        recenter = 1'b0;
        check("rc_y31", paddle_y, 180); check("rc_dir31", dir, 0);
        check("rc_bot31", at_bottom, 0);
        run_to(32); check("rc_y32", paddle_y, 180); check("rc_dir32", dir, 2);
        run_to(33); check("rc_y33_slow", paddle_y, 182);
        run_to(34); check("rc_y34_slow", paddle_y, 184);
        run_to(48); check("rc_y48", paddle_y, 212);
        run_to(49); check("rc_y49_fast", paddle_y, 218);

        // 3-tick glitch on btn_up never reaches the debounced level
        restart();
        btn_up = 1'b1;
        run_to(3);
        btn_up = 1'b0;
        for (int e = 4; e <= 15; e++) begin
            run_to(e);
            check("glitch_y", paddle_y, 180);
            check("glitch_dir", dir, 0);
        end

        // both held freezes the paddle; releasing down lets up through
        restart();
        btn_up   = 1'b1;
        btn_down = 1'b1;
        run_to(20); check("both_dir", dir, 0); check("both_y", paddle_y, 180);
        btn_down = 1'b0;
        run_to(26); check("both_dir26", dir, 0);
        run_to(27); check("both_dir27", dir, 1); check("both_y27", paddle_y, 180);
        run_to(28); check("both_y28", paddle_y, 178);

`ifdef AUTO_PADDLE_EN
        // tracking toward ball_y=400 (target 340); buttons ignored
        auto_mode = 1'b1;
        ball_y    = 10'd400;
        restart();
        btn_up = 1'b1;
        run_to(1);  check("auto_y1", paddle_y, 182); check("auto_dir1", dir, 2);
        run_to(30); check("auto_y30", paddle_y, 240);
        run_to(79); check("auto_y79", paddle_y, 338); check("auto_dir79", dir, 2);
        run_to(80); check("auto_y80", paddle_y, 340); check("auto_dir80", dir, 0);
        run_to(85); check("auto_y85", paddle_y, 340); check("auto_dir85", dir, 0);
        auto_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
